tgmux_sel_gen: RTL

TGMUX_SEL_GEN -- requirements
Module: tgmux_sel_gen

---
 rtl/tgmux_sel_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tgmux_sel_gen.sv
// -----------------------------------------------------------------------------
// tgmux_sel_gen
// Break-before-make select sequencer for a 4:1 transmission-gate mux.
// One path conducts while idle (HOLD). A request for a different path first
// turns every gate off for DEAD_CYC cycles (DEAD) and only then turns the new
// path on, so two paths never conduct in the same cycle. Every output comes
// straight from a flop (CKP through a single inverter on the CKN flops), so
// nothing on the input side can glitch the gate controls.
// -----------------------------------------------------------------------------
module tgmux_sel_gen #(
  parameter int unsigned DEAD_CYC = 2,  // all-off cycles between paths, 1..15
  parameter int unsigned INIT_SEL = 0   // path connected out of reset, 0..3
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       SEL_VLD,
  input  logic [1:0] SEL_IN,
  output logic       SEL_RDY,
  output logic [3:0] CKN,
  output logic [3:0] CKP,
  output logic [1:0] ACT_SEL
);

  // ---------------------------------------------------------------------------
  // Parameter legality: a bad value stops elaboration instead of building
  // a mux with a zero-length or wrapped dead time.
  // ---------------------------------------------------------------------------
  if (DEAD_CYC < 1 || DEAD_CYC > 15) begin : g_bad_dead_cyc
    $error("tgmux_sel_gen: DEAD_CYC=%0d outside 1..15", DEAD_CYC);
  end

  if (INIT_SEL > 3) begin : g_bad_init_sel
    $error("tgmux_sel_gen: INIT_SEL=%0d outside 0..3", INIT_SEL);
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] INIT_IDX  = INIT_SEL[1:0];
  localparam logic [3:0] INIT_CKN  = 4'b0001 << INIT_IDX;
  // Counter is loaded with DEAD_CYC-1 so the path turns on exactly DEAD_CYC
  // edges after acceptance (the load edge itself is the first all-off edge).
  localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYC - 1);

  typedef enum logic {
    S_HOLD = 1'b0,  // one path on, accepting requests
    S_DEAD = 1'b1   // all paths off, waiting out the dead time
  } state_t;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] ckn_q,   ckn_d;
  logic [1:0] act_q,   act_d;
  logic       rdy_q,   rdy_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] tgt_q,   tgt_d;

  logic       accept;

  // Handshake: SEL_RDY is a flop, so acceptance never depends on the same
  // cycle's inputs feeding back into the ready signal.
  assign accept = SEL_VLD & rdy_q;

  // Next-state and next-output computation for the two-state sequencer.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would make synthesis infer a latch to hold it.
    state_d = state_q;
    ckn_d   = ckn_q;
    act_d   = act_q;
    rdy_d   = rdy_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;

    unique case (state_q)
      S_HOLD: begin
        if (accept) begin
          tgt_d = SEL_IN;
          if (SEL_IN != act_q) begin
            // Break first: gates off now, ACT_SEL keeps naming the old path
            // until the new one is actually connected.
            state_d = S_DEAD;
            ckn_d   = 4'b0000;
            rdy_d   = 1'b0;
            cnt_d   = DEAD_LOAD;
          end
        end
      end

      S_DEAD: begin
        // Requests are dropped here: rdy_q is low, so accept cannot fire.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Make: connect the latched target and reopen the handshake.
          state_d = S_HOLD;
          ckn_d   = onehot(tgt_q);
          act_d   = tgt_q;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = S_HOLD;
        ckn_d   = onehot(act_q);
        rdy_d   = 1'b1;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Register all state and outputs; reset forces the INIT_SEL path on at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_HOLD;
      ckn_q   <= INIT_CKN;
      act_q   <= INIT_IDX;
      rdy_q   <= 1'b1;
      cnt_q   <= 4'd0;
      tgt_q   <= INIT_IDX;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values;
      // blocking here would let later lines see already-updated state.
      state_q <= state_d;
      ckn_q   <= ckn_d;
      act_q   <= act_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // CKP is derived from the CKN flops rather than a separate register, so the
  // pair is complementary by construction, including while RSTN is low.
  assign CKN     = ckn_q;
  assign CKP     = ~ckn_q;
  assign SEL_RDY = rdy_q;
  assign ACT_SEL = act_q;

  // ---------------------------------------------------------------------------
  // Internal consistency properties
  // ---------------------------------------------------------------------------
  // At most one gate on at any sampled edge.
  a_onehot0 : assert property (@(posedge CLK) disable iff (!RSTN)
    $countones(ckn_q) <= 1);

  // Ready is high exactly in HOLD, and HOLD always has its path connected.
  a_rdy_state : assert property (@(posedge CLK) disable iff (!RSTN)
    rdy_q == (state_q == S_HOLD));

  a_hold_conn : assert property (@(posedge CLK) disable iff (!RSTN)
    (state_q == S_HOLD) |-> (ckn_q == onehot(act_q)));

  // DEAD always has every gate off.
  a_dead_off : assert property (@(posedge CLK) disable iff (!RSTN)
    (state_q == S_DEAD) |-> (ckn_q == 4'b0000));

endmodule
